// File: rtl/serial_negate_rx.sv
// serial_negate_rx: receive end of the bit-serial two's-complement negation link.
// Collects an LSB-first frame of W bits and undoes the negation bit by bit:
// once a 1 has been seen in the lower bits, every later bit is inverted.
// Both the raw word and the recovered word are assembled in shift registers
// and handed to an output register that the consumer drains over valid/ready.
// The shift registers keep collecting while the output register is full, so
// the sender never has to stall.
module serial_negate_rx #(
    parameter int W = 8
) (
    input  logic         t_clk,
    input  logic         rn,
    input  logic         in_valid,
    input  logic         in_bit,
    input  logic         in_first,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] data,
    output logic [W-1:0] raw,
    output logic         ovf,
    output logic         overrun,
    output logic         frame_err
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

    // The most negative value is its own negation and has no positive form.
    function automatic logic is_most_neg(input logic [W-1:0] v);
        return (v == MOST_NEG);
    endfunction

    rx_state_t     state_r, state_nxt_s;
    logic [CW-1:0] cnt_r, cnt_nxt_s;
    logic          seen_one_r, seen_one_nxt_s;
    logic [W-1:0]  raw_sh_r, raw_sh_nxt_s;
    logic [W-1:0]  rec_sh_r, rec_sh_nxt_s;
    logic          seen_eff_s;
    logic          rec_bit_s;
    logic          complete_s;
    logic          ferr_s;
    logic          accept_s;

    logic          out_valid_r;
    logic [W-1:0]  data_r;
    logic [W-1:0]  raw_r;
    logic          ovf_r;
    logic          overrun_r;
    logic          frame_err_r;

    // Receive FSM next-state: bit recovery, shift-in, frame completion and restart.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        seen_one_nxt_s = seen_one_r;
        raw_sh_nxt_s   = raw_sh_r;
        rec_sh_nxt_s   = rec_sh_r;
        complete_s     = 1'b0;
        ferr_s         = 1'b0;
        // A frame-start bit never inherits history from the previous frame.
        if (in_first) begin
            seen_eff_s = 1'b0;
        end else begin
            seen_eff_s = seen_one_r;
        end
        rec_bit_s = in_bit ^ seen_eff_s;

        case (state_r)
            IDLE: begin
                if (in_valid && in_first) begin
                    raw_sh_nxt_s   = {{(W-1){1'b0}}, in_bit};
                    rec_sh_nxt_s   = {{(W-1){1'b0}}, rec_bit_s};
                    seen_one_nxt_s = in_bit;
                    cnt_nxt_s      = CW'(1);
                    state_nxt_s    = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (in_valid && in_first) begin
                    // Resync: drop the partial frame, this bit opens a new one.
                    ferr_s         = 1'b1;
                    raw_sh_nxt_s   = {{(W-1){1'b0}}, in_bit};
                    rec_sh_nxt_s   = {{(W-1){1'b0}}, rec_bit_s};
                    seen_one_nxt_s = in_bit;
                    cnt_nxt_s      = CW'(1);
                    state_nxt_s    = SHIFT;
                end else if (in_valid) begin
                    raw_sh_nxt_s[cnt_r] = in_bit;
                    rec_sh_nxt_s[cnt_r] = rec_bit_s;
                    seen_one_nxt_s      = seen_one_r | in_bit;
                    if (cnt_r == LAST_IDX) begin
                        complete_s  = 1'b1;
                        cnt_nxt_s   = {CW{1'b0}};
                        state_nxt_s = IDLE;
                    end else begin
                        cnt_nxt_s   = cnt_r + CW'(1);
                        state_nxt_s = SHIFT;
                    end
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            default: begin
                state_nxt_s    = IDLE;
                cnt_nxt_s      = {CW{1'b0}};
                seen_one_nxt_s = 1'b0;
            end
        endcase

        // A finished word is taken if the output slot is free or being drained now.
        accept_s = complete_s && (!out_valid_r || out_ready);
    end

    // Receive FSM and shift-register state.
    always_ff @(posedge t_clk or negedge rn) begin
        if (!rn) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            seen_one_r <= 1'b0;
            raw_sh_r   <= {W{1'b0}};
            rec_sh_r   <= {W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            seen_one_r <= seen_one_nxt_s;
            raw_sh_r   <= raw_sh_nxt_s;
            rec_sh_r   <= rec_sh_nxt_s;
        end
    end

    // Output register with valid/ready handshake and one-cycle status pulses.
    always_ff @(posedge t_clk or negedge rn) begin
        if (!rn) begin
            out_valid_r <= 1'b0;
            data_r      <= {W{1'b0}};
            raw_r       <= {W{1'b0}};
            ovf_r       <= 1'b0;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (accept_s) begin
                out_valid_r <= 1'b1;
                data_r      <= rec_sh_nxt_s;
                raw_r       <= raw_sh_nxt_s;
                ovf_r       <= is_most_neg(raw_sh_nxt_s);
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            overrun_r   <= complete_s && !accept_s;
            frame_err_r <= ferr_s;
        end
    end

    assign out_valid = out_valid_r;
    assign data      = data_r;
    assign raw       = raw_r;
    assign ovf       = ovf_r;
    assign overrun   = overrun_r;
    assign frame_err = frame_err_r;

endmodule
